// File: rtl/taxi_led_pkg.sv
// Shared types for the serial LED shift-register driver.
// Per-LED mode encoding, FSM states and activity reload value.
package taxi_led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_ACT   = 2'b11
  } led_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } sreg_state_t;

  localparam logic [1:0] ACT_RELOAD = 2'd3;

endpackage

// File: rtl/taxi_led_act_stretch.sv
// Single-LED activity stretch counter (reload on act, decay on act_tick).
// Ports: clk, rst_n, act, act_tick in; on out (counter nonzero).
module taxi_led_act_stretch
  import taxi_led_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic act,
  input  logic act_tick,
  output logic on
);

  logic [1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (act) begin
      cnt_q <= ACT_RELOAD;
    end else if (act_tick && cnt_q != 2'd0) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  assign on = |cnt_q;

endmodule

// File: rtl/taxi_led_sreg_mode.sv
// Serial LED shift-register driver with per-LED off/on/blink/activity modes.
// Ports: clk, rst_n, led_mode, led_act in; sreg_d, sreg_clk, sreg_ld, busy out.
module taxi_led_sreg_mode
  import taxi_led_pkg::*;
#(
  parameter int COUNT    = 16,
  parameter int PRESCALE = 31,
  parameter int BLINK_W  = 24,
  parameter int ACT_W    = 20,
  parameter int INVERT   = 0,
  parameter int REVERSE  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*COUNT-1:0] led_mode,
  input  logic [COUNT-1:0]   led_act,
  output logic               sreg_d,
  output logic               sreg_clk,
  output logic               sreg_ld,
  output logic               busy
);

  localparam int PS_W  = PRESCALE > 0 ? $clog2(PRESCALE + 1) : 1;
  localparam int IDX_W = COUNT > 1 ? $clog2(COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

  logic [PS_W-1:0]    ps_q;
  logic [BLINK_W-1:0] blink_q;
  logic [ACT_W-1:0]   act_q;
  logic               tick;
  logic               act_tick;

  assign tick     = (ps_q == PS_W'(PRESCALE));
  assign act_tick = &act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q    <= '0;
      blink_q <= '0;
      act_q   <= '0;
    end else begin
      ps_q    <= tick ? '0 : ps_q + 1'b1;
      blink_q <= blink_q + 1'b1;
      act_q   <= act_q + 1'b1;
    end
  end

  logic [COUNT-1:0] st_on;

  for (genvar g = 0; g < COUNT; g++) begin : g_act
    taxi_led_act_stretch u_act (
      .clk      (clk),
      .rst_n    (rst_n),
      .act      (led_act[g]),
      .act_tick (act_tick),
      .on       (st_on[g])
    );
  end

  logic [COUNT-1:0] disp_d;
  logic [COUNT-1:0] disp_q;
  led_mode_t        m;

  // led_act is ORed in so an activity pulse shows with the same
  // one-cycle lag as the other modes.
  always_comb begin
    disp_d = '0;
    m      = LED_OFF;
    for (int i = 0; i < COUNT; i++) begin
      m = led_mode_t'(led_mode[2*i +: 2]);
      unique case (1'b1)
        (m == LED_OFF):   disp_d[i] = 1'b0;
        (m == LED_ON):    disp_d[i] = 1'b1;
        (m == LED_BLINK): disp_d[i] = blink_q[BLINK_W-1];
        (m == LED_ACT):   disp_d[i] = led_act[i] | st_on[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_q <= '0;
    else        disp_q <= disp_d;
  end

  function automatic logic pick(
    input logic [COUNT-1:0] v,
    input logic [IDX_W-1:0] k
  );
    logic [COUNT-1:0] o;
    for (int j = 0; j < COUNT; j++) begin
      o[j] = (REVERSE != 0) ? v[j] : v[COUNT-1-j];
    end
    return o[k] ^ (INVERT != 0);
  endfunction

  sreg_state_t      state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [COUNT-1:0] shadow_q, shadow_n;
  logic [COUNT-1:0] shown_q, shown_n;
  logic             fv_q, fv_n;
  logic             d_n, c_n, ld_n, busy_n;

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    shadow_n = shadow_q;
    shown_n  = shown_q;
    fv_n     = fv_q;
    d_n      = sreg_d;
    c_n      = sreg_clk;
    ld_n     = sreg_ld;
    busy_n   = busy;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fv_q || disp_q != shown_q) begin
            shadow_n = disp_q;
            idx_n    = '0;
            busy_n   = 1'b1;
            c_n      = 1'b0;
            d_n      = pick(disp_q, '0);
            state_n  = ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          c_n     = 1'b1;
          state_n = ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          c_n = 1'b0;
          if (idx_q == LAST) begin
            d_n     = 1'b0;
            ld_n    = 1'b1;
            state_n = ST_LATCH;
          end else begin
            idx_n   = idx_q + 1'b1;
            d_n     = pick(shadow_q, idx_q + 1'b1);
            state_n = ST_SHIFT_LO;
          end
        end
        ST_LATCH: begin
          ld_n    = 1'b0;
          busy_n  = 1'b0;
          shown_n = shadow_q;
          fv_n    = 1'b1;
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      shown_q  <= '0;
      fv_q     <= 1'b0;
      sreg_d   <= 1'b0;
      sreg_clk <= 1'b0;
      sreg_ld  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      shadow_q <= shadow_n;
      shown_q  <= shown_n;
      fv_q     <= fv_n;
      sreg_d   <= d_n;
      sreg_clk <= c_n;
      sreg_ld  <= ld_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_taxi_led_sreg_mode.sv
// Scoreboard bench: two drivers (plain, inverted+reversed) on shared inputs.
// Frames are decoded from the pins and checked against queued expectations.
module tb_taxi_led_sreg_mode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led_mode = '0;
  logic [3:0] led_act = '0;
  logic [1:0] sd, sc, sl, sb;

  int total = 0;
  int bad = 0;

  logic [3:0] exp_a[$];
  logic [3:0] exp_b[$];
  logic [31:0] cyc;

  always #5 clk = ~clk;

  taxi_led_sreg_mode #(
    .COUNT(4), .PRESCALE(1), .BLINK_W(6),
    .ACT_W(4), .INVERT(0), .REVERSE(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .led_mode(led_mode), .led_act(led_act),
    .sreg_d(sd[0]), .sreg_clk(sc[0]),
    .sreg_ld(sl[0]), .busy(sb[0])
  );

  taxi_led_sreg_mode #(
    .COUNT(4), .PRESCALE(1), .BLINK_W(6),
    .ACT_W(4), .INVERT(1), .REVERSE(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .led_mode(led_mode), .led_act(led_act),
    .sreg_d(sd[1]), .sreg_clk(sc[1]),
    .sreg_ld(sl[1]), .busy(sb[1])
  );

  // Mirrors the free-running blink/activity counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [3:0] flip(input logic [3:0] v);
    return ~{v[0], v[1], v[2], v[3]};
  endfunction

  task automatic push_exp(input logic [3:0] v);
    exp_a.push_back(v);
    exp_b.push_back(flip(v));
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_a.size() == 0 && exp_b.size() == 0 && sb == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain: pending a=%0d b=%0d busy=%b want 0 0 00",
               exp_a.size(), exp_b.size(), sb);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    total++;
    if ({sd, sc, sl, sb} !== 8'h00) begin
      bad++;
      $display("FAIL %s: d=%b c=%b ld=%b busy=%b want all 0",
               nm, sd, sc, sl, sb);
    end
  endtask

  // Monitor: rebuild each frame from sreg_clk rising edges.
  logic [3:0] sh[2];
  int nb[2], bc[2], lc[2];
  logic pc[2], pl[2], pb[2];

  initial begin
    logic [3:0] e;
    bit empty;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          sh[i] = '0; nb[i] = 0; bc[i] = 0; lc[i] = 0;
          pc[i] = 1'b0; pl[i] = 1'b0; pb[i] = 1'b0;
        end else begin
          if (sc[i] && !pc[i]) begin
            sh[i] = {sh[i][2:0], sd[i]};
            nb[i]++;
          end
          if (sl[i] && !pl[i]) begin
            total++;
            empty = (i == 0) ? (exp_a.size() == 0)
                             : (exp_b.size() == 0);
            if (empty) begin
              bad++;
              $display("FAIL frame%0d: unexpected frame %b", i, sh[i]);
            end else begin
              if (i == 0) e = exp_a.pop_front();
              else        e = exp_b.pop_front();
              if (sh[i] !== e || nb[i] != 4) begin
                bad++;
                $display("FAIL frame%0d: got %b (%0d bits) want %b (4)",
                         i, sh[i], nb[i], e);
              end
            end
            sh[i] = '0;
            nb[i] = 0;
          end
          if (sl[i]) lc[i]++;
          if (!sl[i] && pl[i]) begin
            total++;
            if (lc[i] != 2) begin
              bad++;
              $display("FAIL ld_len%0d: got %0d want 2", i, lc[i]);
            end
            lc[i] = 0;
          end
          if (sb[i]) bc[i]++;
          if (!sb[i] && pb[i]) begin
            total++;
            if (bc[i] != 18) begin
              bad++;
              $display("FAIL busy_len%0d: got %0d want 18", i, bc[i]);
            end
            bc[i] = 0;
          end
          if (!sb[i]) begin
            total++;
            if (sc[i] | sd[i] | sl[i]) begin
              bad++;
              $display("FAIL idle_pins%0d: c=%b d=%b ld=%b want 000",
                       i, sc[i], sd[i], sl[i]);
            end
          end
          pc[i] = sc[i];
          pl[i] = sl[i];
          pb[i] = sb[i];
        end
      end
    end
  end

  initial begin
    logic b;
    bit hit;

    // Forced frame after reset, all LEDs off.
    repeat (3) @(negedge clk);
    check_zero("reset_pins");
    push_exp(4'b0000);
    #2 rst_n = 1'b1;
    wait_drain(100);
    repeat (60) @(negedge clk);

    // Static on/off pattern LED3..0 = 1,0,1,1.
    led_mode = 8'b01_00_01_01;
    push_exp(4'b1011);
    wait_drain(100);

    // Blink on LED0: one frame per toggle, four frames.
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cyc[4:0] == 5'd8) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL blink_phase: not found, want phase 8");
    end
    b = cyc[5];
    push_exp({3'b000, b});
    push_exp({3'b000, ~b});
    push_exp({3'b000, b});
    push_exp({3'b000, ~b});
    led_mode = 8'b00_00_00_10;
    repeat (112) @(negedge clk);
    led_mode = 8'b00_00_00_00;
    if (!b) push_exp(4'b0000);
    wait_drain(100);

    // Activity on LED2: on frame, stretched, one off frame.
    led_mode = 8'b00_11_00_00;
    repeat (10) @(negedge clk);
    push_exp(4'b0100);
    push_exp(4'b0000);
    led_act = 4'b0100;
    @(negedge clk);
    led_act = 4'b0000;
    repeat (20) @(negedge clk);
    led_act = 4'b0100;
    @(negedge clk);
    led_act = 4'b0000;
    repeat (30) @(negedge clk);
    total++;
    if (exp_a.size() != 1 || sb[0] !== 1'b0) begin
      bad++;
      $display("FAIL act_extend: pending=%0d busy=%b want 1 0",
               exp_a.size(), sb[0]);
    end
    wait_drain(200);

    // Reset during SHIFT_HI, then a full forced frame.
    led_mode = 8'b01_00_01_01;
    hit = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sc[0] && sb[0]) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL shift_hi_seen: got none want sreg_clk=1");
    end
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    repeat (3) @(negedge clk);
    check_zero("held_reset");
    push_exp(4'b1011);
    #2 rst_n = 1'b1;
    wait_drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
